apb_slave_regfile: RTL
======================

# apb_slave_regfile

APB completer holding a bank of 32-bit read/write registers, serving as the downstream endpoint of the ICB-to-APB bridge on the `apb_bus` interface. It decodes setup/access phases, inserts a configurable number of wait states before a one-cycle `pready` pulse, and flags out-of-range accesses with `pslverr`. It is both a synthesizable peripheral and the bench's reference slave, so the bridge and the APB protocol checkers are exercised against real wait-state behaviour.

## Interface
- `ADDR_W`, 32, APB address width.
- `DATA_W`, 32, APB data width and register width.
- `NUM_REGS`, 16, number of registers. Word index is `paddr[ADDR_W-1:2]`; `paddr[1:0]` is ignored.
- `WAIT_CYCLES`, 0, fixed wait states inserted per access, legal range 0..15.

Ports:
- `clk`  in  1  single clock; all state is updated on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `psel`  in  1  slave select.
- `penable`  in  1  access phase.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  `ADDR_W`  byte address.
- `pwdata`  in  `DATA_W`  write data.
- `prdata`  out  `DATA_W`  read data; valid while `pready` is high on a read.
- `pready`  out  1  transfer-complete pulse.
- `pslverr`  out  1  error response; valid only while `pready` is high.

## Operation
- FSM states: IDLE, ACCESS.
- **IDLE**
  - `psel && !penable` is a setup phase. On that edge the block captures `pwrite`, the index and `pwdata`, loads the wait counter `cnt` with the wait value and moves to ACCESS.
  - `penable` high without a preceding setup is ignored; the FSM stays in IDLE.
- **ACCESS**
  - If `cnt != 0`, `cnt` decrements each cycle.
  - While `cnt == 0`, `pready` = 1.
  - The write commits on the edge where `pready`, `psel` and `penable` are all high. The FSM then returns to IDLE unconditionally.
  - A back-to-back transfer therefore starts with a new setup phase in the following cycle.
- **Abort:** `psel` low in ACCESS before completion is a protocol violation. The FSM returns to IDLE, no write is performed and `pready` is not asserted.
- **Reads:** `prdata` is loaded with `regs[idx]` at the setup edge and held until the next read setup.
- **Out-of-range** (`idx >= NUM_REGS`):
  - Writes are dropped.
  - Reads load `prdata` = 0.
  - `pslverr` = 1 during the `pready` cycle.
- `pready` and `pslverr` are decoded only from registered state (`state`, `cnt`, captured error flag). There is no combinational path from the APB inputs to any output.

## Timing
- **Reset values:** state = IDLE, `cnt` = 0, all registers = 0, `prdata` = 0, `pready` = 0, `pslverr` = 0.
- **Latency:** setup at cycle T, then `pready` high in cycle T+1+W, where W is the wait value.
  - With W = 0, this gives the minimum 2-cycle APB transfer.
- `pready` is high for exactly one cycle per transfer and is low in the cycle after it.
- Address, control and write data are sampled only at setup. Changes in the access phase are ignored; the bus checker flags them separately.
- A read of a register in the cycle right after its write sees the new value, because the write commits before the next setup edge.
- Reset mid-transfer: the FSM goes to IDLE immediately, with no `pready` and no write. Registers are cleared.

## Configuration
- **`APB_SLV_RAND_WAIT_EN` defined:**
  - The wait value comes from a 4-bit LFSR (taps x^4+x^3+1, seed 4'b1001 at reset).
  - The LFSR advances once per accepted setup.
  - W = `lfsr[1:0]`, giving 0..3 wait states.
  - `WAIT_CYCLES` is unused.
- **Not defined:** W = `WAIT_CYCLES` for every transfer. No LFSR is present.

## Test plan
- **Reset values:** assert reset, release, idle 5 cycles. Required: `pready`, `pslverr`, `prdata` all 0.
- **Zero-wait write/read:** WAIT_CYCLES=0; write 0xA5A5_0001 to 0x08, then read 0x08.
  - Required: each `pready` is high in the cycle after setup.
  - Required: the read returns 0xA5A5_0001 and `pslverr` = 0.
- **Fixed wait states:** WAIT_CYCLES=3; read 0x00.
  - Required: `pready` is high exactly at setup+4, for one cycle.
  - Required: `prdata` = 0.
- **Out of range:** NUM_REGS=16; write 0x1234 to 0x40, then read 0x40.
  - Required: both transfers complete with `pslverr` = 1.
  - Required: the read returns 0 and registers 0..15 are unchanged.
- **Abort and reset:**
  - Drop `psel` during the ACCESS wait of a write of 0xFFFF_FFFF to 0x04. Required: no `pready`, and register 1 keeps its old value.
  - Assert `rst_n` low mid-ACCESS. Required: outputs are 0 immediately and the FSM is in IDLE.
- **Random waits (with `APB_SLV_RAND_WAIT_EN` defined):** 20 back-to-back writes then reads over indices 0..15.
  - Required: every wait is in 0..3, with the first W = 1 (seed 1001).
  - Required: all readback data matches.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// APB completer with a bank of NUM_REGS read/write registers and per-access wait states.
// Define APB_SLV_RAND_WAIT_EN for LFSR-driven wait states (0..3) instead of WAIT_CYCLES.
module apb_slave_regfile #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);
  localparam int IDX_W = ADDR_W - 2;
  localparam int RI_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0] LIMIT = IDX_W'(NUM_REGS);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d, err_q, err_d;
  logic [RI_W-1:0]     ridx_q, ridx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, prdata_q, prdata_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [IDX_W-1:0]    idx;
  logic [RI_W-1:0]     ridx;
  logic                in_range, setup, commit;
  logic [3:0]          wait_val;

  assign idx      = paddr[ADDR_W-1:2];
  assign ridx     = idx[RI_W-1:0];
  assign in_range = (idx < LIMIT);
  assign setup    = (state_q == IDLE) && psel && !penable;

  // Outputs depend on registered state only.
  assign pready  = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign pslverr = pready && err_q;
  assign prdata  = prdata_q;
  assign commit  = pready && psel && penable && wr_q && !err_q;

`ifdef APB_SLV_RAND_WAIT_EN
  logic [3:0] lfsr_q;

  // x^4+x^3+1; the current value sets this access's wait, then it steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     lfsr_q <= 4'b1001;
    else if (setup) lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  end

  assign wait_val = {2'b00, lfsr_q[1:0]};
`else
  assign wait_val = 4'(WAIT_CYCLES);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    err_d    = err_q;
    ridx_d   = ridx_q;
    wdata_d  = wdata_q;
    prdata_d = prdata_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          state_d = ACCESS;
          cnt_d   = wait_val;
          wr_d    = pwrite;
          err_d   = !in_range;
          ridx_d  = ridx;
          wdata_d = pwdata;
          if (!pwrite) prdata_d = in_range ? regs_q[ridx] : '0;
        end
      end
      ACCESS: begin
        // Losing psel mid-access abandons the transfer without a response.
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      ridx_q   <= '0;
      wdata_q  <= '0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      ridx_q   <= ridx_d;
      wdata_q  <= wdata_d;
      prdata_q <= prdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (commit) begin
      regs_q[ridx_q] <= wdata_q;
    end
  end

endmodule
